// File: rtl/ps2_keymatrix_pkg.sv
// Shared definitions for the PS/2 keyboard front end.
// Holds the receive-frame state type, PS/2 prefix byte values, the
// caps-lock scancode and the TI-99/4A matrix index constants for the
// column-0 modifier keys.
package ps2_keymatrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;
  localparam logic [7:0] CODE_CAPS  = 8'h58;

  localparam logic [5:0] IDX_EQUALS = 6'd0;
  localparam logic [5:0] IDX_SPACE  = 6'd1;
  localparam logic [5:0] IDX_ENTER  = 6'd2;
  localparam logic [5:0] IDX_FCTN   = 6'd4;
  localparam logic [5:0] IDX_SHIFT  = 6'd5;
  localparam logic [5:0] IDX_CTRL   = 6'd6;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Scancode (set 2) to TI-99/4A key matrix position table.
// Ports:
//   ext   : 1 when the code was preceded by an 0xE0 prefix
//   code  : PS/2 scancode byte
//   hit   : 1 when the code maps to a matrix key
//   index : matrix position, column*8 + row (valid when hit = 1)
module ps2_keymap
  import ps2_keymatrix_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [5:0] index
);

  always_comb begin
    hit   = 1'b1;
    index = 6'd0;
    case ({ext, code})
      // column 0: modifiers and wide keys
      {1'b0, 8'h55}: index = IDX_EQUALS;
      {1'b0, 8'h29}: index = IDX_SPACE;
      {1'b0, 8'h5A}: index = IDX_ENTER;
      {1'b0, 8'h11}: index = IDX_FCTN;
      {1'b0, 8'h12}: index = IDX_SHIFT;
      {1'b0, 8'h59}: index = IDX_SHIFT;
      {1'b0, 8'h14}: index = IDX_CTRL;
      {1'b1, 8'h14}: index = IDX_CTRL;
      {1'b1, 8'h11}: index = IDX_FCTN;
      {1'b1, 8'h5A}: index = IDX_ENTER;
      // column 1: . L O 9 2 S W X
      {1'b0, 8'h49}: index = 6'd8;
      {1'b0, 8'h4B}: index = 6'd9;
      {1'b0, 8'h44}: index = 6'd10;
      {1'b0, 8'h46}: index = 6'd11;
      {1'b0, 8'h1E}: index = 6'd12;
      {1'b0, 8'h1B}: index = 6'd13;
      {1'b0, 8'h1D}: index = 6'd14;
      {1'b0, 8'h22}: index = 6'd15;
      // column 2: , K I 8 3 D E C
      {1'b0, 8'h41}: index = 6'd16;
      {1'b0, 8'h42}: index = 6'd17;
      {1'b0, 8'h43}: index = 6'd18;
      {1'b0, 8'h3E}: index = 6'd19;
      {1'b0, 8'h26}: index = 6'd20;
      {1'b0, 8'h23}: index = 6'd21;
      {1'b0, 8'h24}: index = 6'd22;
      {1'b0, 8'h21}: index = 6'd23;
      // column 3: M J U 7 4 F R V
      {1'b0, 8'h3A}: index = 6'd24;
      {1'b0, 8'h3B}: index = 6'd25;
      {1'b0, 8'h3C}: index = 6'd26;
      {1'b0, 8'h3D}: index = 6'd27;
      {1'b0, 8'h25}: index = 6'd28;
      {1'b0, 8'h2B}: index = 6'd29;
      {1'b0, 8'h2D}: index = 6'd30;
      {1'b0, 8'h2A}: index = 6'd31;
      // column 4: N H Y 6 5 G T B
      {1'b0, 8'h31}: index = 6'd32;
      {1'b0, 8'h33}: index = 6'd33;
      {1'b0, 8'h35}: index = 6'd34;
      {1'b0, 8'h36}: index = 6'd35;
      {1'b0, 8'h2E}: index = 6'd36;
      {1'b0, 8'h34}: index = 6'd37;
      {1'b0, 8'h2C}: index = 6'd38;
      {1'b0, 8'h32}: index = 6'd39;
      // column 5: / ; P 0 1 A Q Z
      {1'b0, 8'h4A}: index = 6'd40;
      {1'b0, 8'h4C}: index = 6'd41;
      {1'b0, 8'h4D}: index = 6'd42;
      {1'b0, 8'h45}: index = 6'd43;
      {1'b0, 8'h16}: index = 6'd44;
      {1'b0, 8'h1C}: index = 6'd45;
      {1'b0, 8'h15}: index = 6'd46;
      {1'b0, 8'h1A}: index = 6'd47;
      default:       hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// Receive-only PS/2 keyboard front end producing the TI-99/4A key matrix
// image and alpha-lock level.
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   ps2_clk     : raw PS/2 clock pin (asynchronous)
//   ps2_data    : raw PS/2 data pin (asynchronous)
//   key_state   : key-down bitmap, index = column*8 + row, 1 = pressed
//   alpha_state : alpha lock engaged
//   frame_err   : one-cycle pulse on parity/stop error or frame timeout
module ps2_keymatrix
  import ps2_keymatrix_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [0:47] key_state,
  output logic        alpha_state,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          strike;
  logic          strike_bit;

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          byte_vld;
  logic [7:0]    byte_q;

  logic          ext;
  logic          brk;
  logic [2:0]    skip;
  logic          map_hit;
  logic [5:0]    map_idx;

  // Synchronise both pins, debounce the clock, and produce a one-cycle
  // strike on each accepted falling edge together with the data level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      filt_clk   <= 1'b1;
      filt_cnt   <= '0;
      strike     <= 1'b0;
      strike_bit <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      strike     <= 1'b0;
      strike_bit <= data_sync[1];
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        strike   <= filt_clk & ~clk_sync[1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame receiver. A strike always reloads the timeout counter, so a
  // strike coinciding with expiry keeps the frame alive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      byte_vld  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (strike) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            // a high "start bit" is line noise, not a frame
            if (!strike_bit) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {strike_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            // odd parity: data plus parity must hold an odd count of ones
            if ((^shreg) ^ strike_bit) begin
              state <= ST_STOP;
            end else begin
              state     <= ST_IDLE;
              frame_err <= 1'b1;
            end
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (strike_bit) begin
              byte_vld <= 1'b1;
              byte_q   <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          state     <= ST_IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  ps2_keymap u_keymap (
    .ext   (ext),
    .code  (byte_q),
    .hit   (map_hit),
    .index (map_idx)
  );

  // Prefix tracking and key bitmap update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      skip        <= '0;
      key_state   <= '0;
      alpha_state <= 1'b0;
    end else if (byte_vld) begin
      if (skip != 3'd0) begin
        // pause sequence body is swallowed whole, prefixes included
        skip <= skip - 3'd1;
        if (skip == 3'd1) begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end else if (byte_q == CODE_PAUSE) begin
        skip <= 3'd7;
      end else if (byte_q == CODE_EXT) begin
        ext <= 1'b1;
      end else if (byte_q == CODE_BRK) begin
        brk <= 1'b1;
      end else if (is_ignored(byte_q)) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else begin
        if (map_hit) key_state[map_idx] <= ~brk;
        // caps lock is a toggle on every make, repeats included
        if (!ext && !brk && byte_q == CODE_CAPS) alpha_state <= ~alpha_state;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Bench for ps2_keymatrix: drives PS/2 device frames onto the pins and
// checks the key bitmap, alpha lock and error pulses against expectations
// queued as each frame is sent.
module tb_ps2_keymatrix;

  localparam int FILT = 8;
  localparam int TO   = 2000;
  localparam int HALF = 30;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [0:47] key_state;
  logic        alpha_state;
  logic        frame_err;

  ps2_keymatrix #(.FILTER_LEN(FILT), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_state   (key_state),
    .alpha_state (alpha_state),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [0:47] keys;
    logic        alpha;
    int          errs;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int err_cycles = 0;
  int err_pulses = 0;
  int err_cyc = 0;
  logic err_prev = 1'b0;
  int last_fall = 0;

  logic [0:47] exp_keys = '0;
  logic        exp_alpha = 1'b0;
  int          exp_errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) err_cycles <= err_cycles + 1;
    if (frame_err && !err_prev) begin
      err_pulses <= err_pulses + 1;
      err_cyc    <= cyc;
    end
    err_prev <= frame_err;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input string tag, input logic [7:0] b,
                      input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    logic [10:0] f;
    exp_t e;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    e.tag   = tag;
    e.keys  = exp_keys;
    e.alpha = exp_alpha;
    e.errs  = exp_errs;
    sb.push_back(e);
    ps2_bits(f, 11);
    repeat (20) @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_keys"}, 64'(key_state), 64'(e.keys));
    chk({e.tag, "_alpha"}, 64'(alpha_state), 64'(e.alpha));
    chk({e.tag, "_errs"}, 64'(err_pulses), 64'(e.errs));
    chk({e.tag, "_errw"}, 64'(err_cycles), 64'(e.errs));
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pause_seq [8];
    logic       seen;
    int         pulses0;
    int         lat;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_keys", 64'(key_state), 64'd0);
    chk("rst_alpha", 64'(alpha_state), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // make / break of a letter
    exp_keys[45] = 1'b1; send("mk_a", 8'h1C);
    send("f0", 8'hF0);
    exp_keys[45] = 1'b0; send("brk_a", 8'h1C);

    // extended ctrl make and break
    send("e0", 8'hE0);
    exp_keys[6] = 1'b1; send("ext_ctrl", 8'h14);
    send("e0", 8'hE0);
    send("f0", 8'hF0);
    exp_keys[6] = 1'b0; send("ext_brk_ctrl", 8'h14);
    exp_keys[0] = 1'b1; send("mk_eq", 8'h55);
    send("e0", 8'hE0);
    send("ext_unmapped", 8'h1C);
    exp_keys[45] = 1'b1; send("mk_a2", 8'h1C);
    send("f0", 8'hF0);
    exp_keys[45] = 1'b0; send("brk_a2", 8'h1C);
    send("f0", 8'hF0);
    exp_keys[0] = 1'b0; send("brk_eq", 8'h55);

    // shared shift index
    exp_keys[5] = 1'b1; send("mk_lshift", 8'h12);
    send("mk_rshift", 8'h59);
    send("f0", 8'hF0);
    exp_keys[5] = 1'b0; send("brk_lshift", 8'h12);

    // caps lock toggles on make only
    exp_alpha = 1'b1; send("caps1", 8'h58);
    exp_alpha = 1'b0; send("caps2", 8'h58);
    send("f0", 8'hF0);
    send("caps_brk", 8'h58);

    // parity and stop-bit errors
    exp_errs++; send("bad_par", 8'h29, 1'b1, 1'b0);
    exp_keys[1] = 1'b1; send("mk_space", 8'h29);
    exp_errs++; send("bad_stop", 8'h1C, 1'b0, 1'b1);

    // timeout after start + 4 data bits
    pulses0 = err_pulses;
    ps2_bits(11'b00000110100, 5);
    seen = 1'b0;
    for (int i = 0; i < TO + 400 && !seen; i++) begin
      @(negedge clk);
      if (err_pulses > pulses0) seen = 1'b1;
    end
    chk("to_seen", 64'(seen), 64'd1);
    lat = err_cyc - last_fall;
    chk("to_latency", 64'((lat >= TO) && (lat <= TO + FILT + 8)), 64'd1);
    exp_errs++;
    exp_keys[2] = 1'b1; send("mk_enter", 8'h5A);

    // pause sequence swallowed
    foreach (pause_seq[i]) send("pause", pause_seq[i]);
    exp_keys[45] = 1'b1; send("mk_a3", 8'h1C);

    // more table positions
    exp_keys[44] = 1'b1; send("mk_1", 8'h16);
    exp_keys[46] = 1'b1; send("mk_q", 8'h15);
    exp_keys[47] = 1'b1; send("mk_z", 8'h1A);
    exp_keys[40] = 1'b1; send("mk_slash", 8'h4A);
    exp_keys[8]  = 1'b1; send("mk_dot", 8'h49);
    exp_keys[38] = 1'b1; send("mk_t", 8'h2C);
    send("e0", 8'hE0);
    exp_keys[4] = 1'b1; send("ext_alt", 8'h11);
    send("e0", 8'hE0);
    send("f0", 8'hF0);
    exp_keys[2] = 1'b0; send("ext_brk_enter", 8'h5A);
    // ignored byte clears a pending break
    send("f0", 8'hF0);
    send("ack", 8'hAA);
    send("rep_1", 8'h16);

    // reset in the middle of a frame
    exp_alpha = 1'b1; send("caps3", 8'h58);
    ps2_bits(11'b00000001110, 4);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_keys", 64'(key_state), 64'd0);
    chk("mid_rst_alpha", 64'(alpha_state), 64'd0);
    chk("mid_rst_err", 64'(frame_err), 64'd0);
    repeat (5) @(negedge clk);
    reset_n   = 1'b1;
    exp_keys  = '0;
    exp_alpha = 1'b0;
    repeat (10) @(negedge clk);
    exp_keys[45] = 1'b1; send("post_rst_a", 8'h1C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_keymatrix.md
# ps2_keymatrix

Receive-only PS/2 keyboard front end that produces the 48-bit key matrix image and alpha-lock level consumed by the console keyboard matrix scanner. Deserialises PS/2 device-to-host frames, validates them, and tracks make/break/extended prefixes. Maps scancodes to TI-99/4A matrix positions and holds a registered key-down bitmap. Sits between the board PS/2 pins and the keyboard matrix block. Joysticks are out of scope.

## Interface
- FILTER_LEN, 8: cycles the synchronised ps2_clk must be stable before an edge is accepted.
- TIMEOUT, 65536: cycles without an accepted falling edge mid-frame before the frame is abandoned.
- clk  in  1  system clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous.
- ps2_data  in  1  raw PS/2 data pin; asynchronous.
- key_state  out  [0:47]  key-down bitmap; index = column*8 + row; 1 = pressed.
- alpha_state  out  1  alpha lock active, 1 = engaged.
- frame_err  out  1  one-cycle pulse on parity or stop-bit error, or timeout.

## Operation
- Input conditioning: 2-FF synchroniser on both pins; ps2_clk debounced by FILTER_LEN stable-cycle counter; a filtered 1->0 transition is a sample strike; ps2_data is sampled on it.
- Frame FSM: IDLE -> DATA (start bit 0) -> PARITY (after 8 data bits, LSB first) -> STOP -> IDLE.
  - Start bit 1 in IDLE: ignored, stay IDLE, no error.
  - Odd parity fail, or stop bit 0: frame_err pulse, byte discarded, back to IDLE.
  - TIMEOUT cycles in DATA/PARITY/STOP with no strike: frame_err pulse, back to IDLE, partial byte dropped.
- Byte decoder, prefix flags ext and brk:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - 0xE1 loads skip counter with 7; the next 7 bytes are discarded; flags are then cleared.
  - 0xAA, 0xFA, 0xEE, 0x00, 0xFF: ignored; flags cleared.
  - Any other byte is a key code. It is looked up with the current ext, the key bit is set (make) or cleared (brk), then ext and brk clear.
- Map, non-extended:
  - 0x55 '=' -> 0; 0x29 space -> 1; 0x5A enter -> 2; 0x11 L-alt -> 4 (FCTN).
  - 0x12 and 0x59 shifts -> 5; 0x14 L-ctrl -> 6.
  - Letters and digits follow the TI matrix: columns 1-5 rows 0-7, e.g. 0x1C 'A' -> 45, 0x15 'Q' -> 46, 0x1A 'Z' -> 47, 0x16 '1' -> 44.
- Map, extended: E0 14 -> 6; E0 11 -> 4; E0 5A -> 2.
- Unmapped codes change nothing.
- Both shift keys share index 5. Break of either clears it; no per-key reference count.
- Caps lock, 0x58 make (non-extended): toggles alpha_state. Its break is ignored. Typematic repeats of 0x58 make toggle again.
- Typematic repeat of an already-set key: idempotent.

## Timing
- Reset values: key_state all 0, alpha_state 0, frame_err 0, FSM IDLE, ext/brk 0, skip 0, filter and timeout counters 0.
- Reset asserted mid-frame: all of the above immediately. The first frame after release must start with a fresh start bit.
- Strike latency: pin edge -> strike = 2 sync cycles + FILTER_LEN cycles.
- Byte latency: the stop-bit strike at cycle N yields the validated byte at N+1. key_state/alpha_state update at N+2 and are registered.
- frame_err pulses exactly one cycle, at N+1 relative to the failing strike or the timeout expiry.
- A strike and a timeout in the same cycle: the strike wins and the counter reloads.

## Structure
- Package ps2_keymatrix_pkg:
  - frame state enum.
  - prefix byte constants (0xE0, 0xF0, 0xE1).
  - caps-lock code.
  - index constants for FCTN, SHIFT, CTRL, ENTER, SPACE.
- Sub-module ps2_keymap: combinational {ext, code[7:0]} -> {hit, index[5:0]} table.
- Top contains the synchroniser/filter, frame FSM, timeout counter, prefix logic and bitmap register.

## Test plan
- Reset, then frame 0x1C (parity 0): key_state[45]=1 at stop strike +2 cycles; all other bits 0; frame_err never pulses.
- Send F0 1C: key_state[45] returns to 0. Send E0 14, then E0 F0 14: bit 6 sets, then clears; ext/brk clear afterwards.
- Send 12, 59, F0 12: key_state[5]=0 after F0 12. Send 58 twice: alpha_state 0->1->0. Send F0 58: no change.
- Frame 0x29 with wrong parity: one-cycle frame_err pulse, bit 1 stays 0. Next valid 0x29 sets bit 1.
- Stop sending after 4 data bits: frame_err at TIMEOUT cycles. A following full 0x5A frame sets bit 2.
- Send E1 14 77 E1 F0 14 F0 77, then 1C: no bits change from the E1 sequence, bit 45 sets. Assert reset_n mid-frame: all outputs 0 within the reset cycle.
